// File: rtl/wave_rv_pkg.sv
// Shared WaveRV load/store definitions: funct3 encodings, LSU state type and
// the request decode helpers used by the load/store unit.
package wave_rv_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESPOND} lsu_state_t;

  // Unsigned load variants have no store counterpart.
  function automatic logic access_legal(input logic store, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_BYTE:   ok = 1'b1;
      F3_HALF:   ok = !a[0];
      F3_WORD:   ok = (a == 2'b00);
      F3_BYTE_U: ok = !store;
      F3_HALF_U: ok = !store && !a[0];
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] write_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] write_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the data-memory port of the LSU.
interface load_store_unit_if #(
  parameter int MEM_ADDRESS_WIDTH = 24
);
  logic                         request_valid;
  logic                         request_ready;
  logic                         request_store;
  logic [2:0]                   request_funct3;
  logic [31:0]                  request_address;
  logic [31:0]                  request_store_data;
  logic                         response_valid;
  logic                         response_error;
  logic [31:0]                  response_load_data;
  logic [MEM_ADDRESS_WIDTH-1:0] memory_address;
  logic                         memory_write_enable;
  logic [3:0]                   memory_write_mask;
  logic [31:0]                  memory_write_data;
  logic [31:0]                  memory_read_data;

  modport slave (
    input  request_valid, request_store, request_funct3, request_address,
           request_store_data, memory_read_data,
    output request_ready, response_valid, response_error, response_load_data,
           memory_address, memory_write_enable, memory_write_mask, memory_write_data
  );

  modport master (
    output request_valid, request_store, request_funct3, request_address,
           request_store_data, memory_read_data,
    input  request_ready, response_valid, response_error, response_load_data,
           memory_address, memory_write_enable, memory_write_mask, memory_write_data
  );
endinterface

// File: rtl/load_aligner.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it to 32 bits (funct3[2] selects zero extension).
module load_aligner (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i[1:0])
      2'b00:   result_o = {{24{byte_sel[7] & ~funct3_i[2]}}, byte_sel};
      2'b01:   result_o = {{16{half_sel[15] & ~funct3_i[2]}}, half_sel};
      default: result_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// WaveRV load/store unit: one access at a time between execute and the
// word-addressed data memory, with registered memory and response outputs.
module load_store_unit
  import wave_rv_pkg::*;
#(
  parameter int MEM_ADDRESS_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  lsu_state_t                   state_q;
  logic                         store_q;
  logic [2:0]                   funct3_q;
  logic [1:0]                   addr_lo_q;
  logic                         ready_q, rsp_valid_q, rsp_error_q;
  logic [31:0]                  rsp_data_q;
  logic [MEM_ADDRESS_WIDTH-1:0] mem_addr_q;
  logic                         mem_we_q;
  logic [3:0]                   mem_mask_q;
  logic [31:0]                  mem_wdata_q;

  logic        legal_d;
  logic [3:0]  mask_d;
  logic [31:0] wdata_d;
  logic [31:0] aligned_d;

  assign legal_d = access_legal(bus.request_store, bus.request_funct3, bus.request_address[1:0]);
  assign mask_d  = write_mask(bus.request_funct3, bus.request_address[1:0]);
  assign wdata_d = write_data(bus.request_funct3, bus.request_store_data);

  load_aligner u_aligner (
    .rdata_i   (bus.memory_read_data),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (aligned_d)
  );

  // Memory outputs only change on entry to ACCESS; write enable is the sole
  // gated strobe, so reset clears it asynchronously and aborts any store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.request_valid) begin
            store_q   <= bus.request_store;
            funct3_q  <= bus.request_funct3;
            addr_lo_q <= bus.request_address[1:0];
            ready_q   <= 1'b0;
            if (!legal_d) begin
              rsp_error_q <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESPOND;
            end else begin
              mem_addr_q  <= bus.request_address[MEM_ADDRESS_WIDTH+1:2];
              mem_we_q    <= bus.request_store;
              mem_mask_q  <= mask_d;
              mem_wdata_q <= wdata_d;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (store_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESPOND;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_data_q  <= aligned_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESPOND;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_data_q  <= '0;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.request_ready       = ready_q;
  assign bus.response_valid      = rsp_valid_q;
  assign bus.response_error      = rsp_error_q;
  assign bus.response_load_data  = rsp_data_q;
  assign bus.memory_address      = mem_addr_q;
  assign bus.memory_write_enable = mem_we_q;
  assign bus.memory_write_mask   = mem_mask_q;
  assign bus.memory_write_data   = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data memory, response scoreboard
// with latency tracking, and directed store/load/error/reset sequences.
module tb_load_store_unit;
  import wave_rv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if #(.MEM_ADDRESS_WIDTH(24)) bus();
  load_store_unit #(.MEM_ADDRESS_WIDTH(24)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [0:1023] = '{default: 32'h0};

  always @(posedge clk) begin
    if (bus.memory_write_enable)
      for (int b = 0; b < 4; b++)
        if (bus.memory_write_mask[b])
          mem[bus.memory_address[9:0]][8*b +: 8] <= bus.memory_write_data[8*b +: 8];
    bus.memory_read_data <= mem[bus.memory_address[9:0]];
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, n_acc = 0, n_resp = 0, we_cnt = 0, n_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.request_valid && bus.request_ready) begin
      acc_cyc <= cyc + 1;
      n_acc   <= n_acc + 1;
    end
  end

  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memory_write_enable) we_cnt <= we_cnt + 1;
      if (bus.response_valid) begin
        n_resp <= n_resp + 1;
        if (sbq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          check("rsp_err", {31'd0, bus.response_error}, {31'd0, e.err});
          check("rsp_data", bus.response_load_data, e.data);
          check("rsp_latency", cyc - acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic expect_rsp(input logic err, input logic [31:0] data, input int lat);
    exp_t x;
    x.err = err; x.data = data; x.lat = lat;
    sbq.push_back(x);
    n_exp++;
  endtask

  // Called on a negedge; returns on the negedge of the first cycle after acceptance.
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
    int w;
    w = 0;
    while (!bus.request_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.request_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.request_valid      = 1'b1;
    bus.request_store      = st;
    bus.request_funct3     = f3;
    bus.request_address    = a;
    bus.request_store_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.request_valid = 1'b0;
    check("ready_busy", {31'd0, bus.request_ready}, 32'd0);
  endtask

  logic [31:0] ld_addr [5] = '{32'h102, 32'h103, 32'h102, 32'h100, 32'h100};
  logic [2:0]  ld_f3   [5] = '{F3_BYTE, F3_BYTE_U, F3_HALF, F3_HALF_U, F3_WORD};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
  logic        er_st   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  er_f3   [4] = '{F3_WORD, F3_HALF, 3'b011, 3'b100};
  logic [31:0] er_addr [4] = '{32'h102, 32'h101, 32'h100, 32'h100};

  initial begin
    int we0, a_sw, acc0, k;
    reset = 1'b1;
    bus.request_valid = 1'b0; bus.request_store = 1'b0; bus.request_funct3 = '0;
    bus.request_address = '0; bus.request_store_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.request_ready}, 32'd1);
    check("rst_ctrl", {28'd0, bus.response_valid, bus.response_error, bus.memory_write_enable, 1'b0},
          32'd0);
    check("rst_mask", {28'd0, bus.memory_write_mask}, 32'd0);
    check("rst_addr", {8'd0, bus.memory_address}, 32'd0);
    check("rst_wdata", bus.memory_write_data, 32'd0);
    check("rst_ldata", bus.response_load_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // SB into the top lane of word 0x40
    expect_rsp(1'b0, 32'h0, 2);
    send(1'b1, F3_BYTE, 32'h103, 32'h000000AB);
    check("sb_addr", {8'd0, bus.memory_address}, 32'h40);
    check("sb_mask", {28'd0, bus.memory_write_mask}, 32'h8);
    check("sb_wdata", bus.memory_write_data, 32'hABABABAB);
    check("sb_we", {31'd0, bus.memory_write_enable}, 32'd1);
    @(negedge clk);
    check("sb_we_drop", {31'd0, bus.memory_write_enable}, 32'd0);
    check("sb_mem", mem[10'h40], 32'hAB000000);

    expect_rsp(1'b0, 32'h0, 2);
    send(1'b1, F3_WORD, 32'h100, 32'h80FF7F01);
    check("sw_mask", {28'd0, bus.memory_write_mask}, 32'hF);
    check("sw_wdata", bus.memory_write_data, 32'h80FF7F01);

    for (int i = 0; i < 5; i++) begin
      expect_rsp(1'b0, ld_exp[i], 3);
      send(1'b0, ld_f3[i], ld_addr[i], 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      expect_rsp(1'b0, ld_model(32'h80FF7F01, i[1:0], F3_BYTE), 3);
      send(1'b0, F3_BYTE, 32'h100 + i, 32'h0);
      expect_rsp(1'b0, ld_model(32'h80FF7F01, i[1:0], F3_BYTE_U), 3);
      send(1'b0, F3_BYTE_U, 32'h100 + i, 32'h0);
    end

    we0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      expect_rsp(1'b1, 32'h0, 1);
      send(er_st[i], er_f3[i], er_addr[i], 32'hFFFFFFFF);
    end
    @(negedge clk);
    check("err_no_we", we_cnt, we0);

    expect_rsp(1'b0, 32'h0, 2);
    send(1'b1, F3_WORD, 32'h200, 32'hDEADBEEF);
    a_sw = acc_cyc;
    expect_rsp(1'b0, 32'hDEADBEEF, 3);
    send(1'b0, F3_WORD, 32'h200, 32'h0);
    check("b2b_spacing", acc_cyc - a_sw, 32'd3);

    expect_rsp(1'b0, 32'h0, 2);
    send(1'b1, F3_HALF, 32'h202, 32'h0000CAFE);
    check("sh_mask", {28'd0, bus.memory_write_mask}, 32'hC);
    check("sh_wdata", bus.memory_write_data, 32'hCAFECAFE);
    expect_rsp(1'b0, 32'h0000CAFE, 3);
    send(1'b0, F3_HALF_U, 32'h202, 32'h0);
    expect_rsp(1'b0, 32'hFFFFFFBE, 3);
    send(1'b0, F3_BYTE, 32'h201, 32'h0);

    // Reset pulse inside the ACCESS cycle of a store
    k = 0;
    while (!bus.request_ready && k < 20) begin @(negedge clk); k++; end
    bus.request_valid = 1'b1; bus.request_store = 1'b1; bus.request_funct3 = F3_WORD;
    bus.request_address = 32'h200; bus.request_store_data = 32'h12345678;
    @(posedge clk);
    #1 check("abort_we_hi", {31'd0, bus.memory_write_enable}, 32'd1);
    #1 reset = 1'b1;
    #1 check("abort_we_lo", {31'd0, bus.memory_write_enable}, 32'd0);
    #1 reset = 1'b0;
    bus.request_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ready", {31'd0, bus.request_ready}, 32'd1);
    check("abort_mem", mem[10'h80], 32'hCAFEBEEF);

    // request_valid wiggled while busy must not start a second access
    acc0 = n_acc; we0 = we_cnt;
    expect_rsp(1'b0, 32'h80FF7F01, 3);
    send(1'b0, F3_WORD, 32'h100, 32'h0);
    bus.request_store = 1'b1; bus.request_funct3 = F3_WORD;
    bus.request_address = 32'h300; bus.request_store_data = 32'h55;
    bus.request_valid = 1'b1;
    @(negedge clk); bus.request_valid = 1'b0;
    @(negedge clk); bus.request_valid = 1'b1;
    @(negedge clk); bus.request_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_one_accept", n_acc - acc0, 32'd1);
    check("busy_no_we", we_cnt, we0);
    check("busy_mem", mem[10'hC0], 32'h0);

    k = 0;
    while (sbq.size() != 0 && k < 20) begin @(negedge clk); k++; end
    check("sb_drained", sbq.size(), 32'd0);
    check("rsp_count", n_resp, n_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
